// File: rtl/player_fsm.sv
// Fighting-game player controller: walk, neutral/directional attacks and
// hit/block stun, all paced by the per-frame tick.
module player_fsm #(
  parameter int unsigned IS_P2    = 0,
  parameter logic [9:0]  START_X  = 10'd128,
  parameter int unsigned SPD_FWD  = 3,
  parameter int unsigned SPD_BACK = 2,
  parameter int unsigned T_NSU    = 5,
  parameter int unsigned T_NACT   = 2,
  parameter int unsigned T_NREC   = 16,
  parameter int unsigned T_DSU    = 4,
  parameter int unsigned T_DACT   = 3,
  parameter int unsigned T_DREC   = 15,
  parameter int unsigned T_HIT    = 15,
  parameter int unsigned T_BLK    = 3
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       got_hit,
  input  logic       got_blocked,
  input  logic [9:0] opponent_x,
  output logic [9:0] player_x,
  output logic [3:0] player_state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MOVE_FWD   = 4'd1,
    MOVE_BACK  = 4'd2,
    N_STARTUP  = 4'd3,
    N_ACTIVE   = 4'd4,
    N_RECOVERY = 4'd5,
    D_STARTUP  = 4'd6,
    D_ACTIVE   = 4'd7,
    D_RECOVERY = 4'd8,
    HITSTUN    = 4'd9,
    BLOCKSTUN  = 4'd10
  } state_t;

  localparam bit                 P2 = (IS_P2 != 0);
  localparam logic signed [11:0] SF = 12'(SPD_FWD);
  localparam logic signed [11:0] SB = 12'(SPD_BACK);

  // Zero-length phases still occupy one frame; oversize values saturate.
  function automatic logic [7:0] dur(input int unsigned t);
    if (t == 0)        return 8'd1;
    else if (t > 255)  return 8'd255;
    else               return 8'(t);
  endfunction

  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < 12'sd0)        return '0;
    else if (v > 12'sd576) return 10'd576;
    else                   return v[9:0];
  endfunction

  state_t     state_q;
  logic [9:0] x_q;
  logic [7:0] cnt_q;
  logic       atk_prev_q;

  logic              fwd_btn, back_btn, atk_edge, last;
  logic signed [11:0] xs, os, lim, step_f, fwd_raw, back_raw;
  logic [9:0]        fwd_x_d, back_x_d;

  assign fwd_btn  = P2 ? btn_left  : btn_right;
  assign back_btn = P2 ? btn_right : btn_left;
  assign atk_edge = btn_attack & ~atk_prev_q;
  assign last     = (cnt_q <= 8'd1);

  // A forward limit behind the current position (overlap) freezes x.
  always_comb begin
    xs     = signed'({2'b00, x_q});
    os     = signed'({2'b00, opponent_x});
    lim    = '0;
    step_f = '0;
    if (!P2) begin
      lim    = os - 12'sd64;
      step_f = xs + SF;
      if (lim < xs)          fwd_raw = xs;
      else if (step_f < lim) fwd_raw = step_f;
      else                   fwd_raw = lim;
      back_raw = xs - SB;
    end else begin
      lim    = os + 12'sd64;
      step_f = xs - SF;
      if (lim > xs)          fwd_raw = xs;
      else if (step_f > lim) fwd_raw = step_f;
      else                   fwd_raw = lim;
      back_raw = xs + SB;
    end
    fwd_x_d  = clamp_x(fwd_raw);
    back_x_d = clamp_x(back_raw);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= START_X;
      cnt_q      <= '0;
      atk_prev_q <= 1'b0;
    end else begin
      if (frame_tick) atk_prev_q <= btn_attack;
      if (got_hit) begin
        state_q <= HITSTUN;
        cnt_q   <= dur(T_HIT);
      end else if (got_blocked) begin
        state_q <= BLOCKSTUN;
        cnt_q   <= dur(T_BLK);
      end else if (frame_tick) begin
        case (state_q)
          IDLE, MOVE_FWD, MOVE_BACK: begin
            if (atk_edge && (fwd_btn ^ back_btn)) begin
              state_q <= D_STARTUP;
              cnt_q   <= dur(T_DSU);
            end else if (atk_edge) begin
              state_q <= N_STARTUP;
              cnt_q   <= dur(T_NSU);
            end else if (fwd_btn && !back_btn) begin
              state_q <= MOVE_FWD;
              x_q     <= fwd_x_d;
            end else if (back_btn && !fwd_btn) begin
              state_q <= MOVE_BACK;
              x_q     <= back_x_d;
            end else begin
              state_q <= IDLE;
            end
          end
          N_STARTUP:
            if (last) begin state_q <= N_ACTIVE; cnt_q <= dur(T_NACT); end
            else cnt_q <= cnt_q - 8'd1;
          N_ACTIVE:
            if (last) begin state_q <= N_RECOVERY; cnt_q <= dur(T_NREC); end
            else cnt_q <= cnt_q - 8'd1;
          D_STARTUP:
            if (last) begin state_q <= D_ACTIVE; cnt_q <= dur(T_DACT); end
            else cnt_q <= cnt_q - 8'd1;
          D_ACTIVE:
            if (last) begin state_q <= D_RECOVERY; cnt_q <= dur(T_DREC); end
            else cnt_q <= cnt_q - 8'd1;
          N_RECOVERY, D_RECOVERY, HITSTUN, BLOCKSTUN:
            if (last) begin state_q <= IDLE; cnt_q <= '0; end
            else cnt_q <= cnt_q - 8'd1;
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign player_x     = x_q;
  assign player_state = state_q;

endmodule

// File: tb/tb_player_fsm.sv
// Directed bench: four player instances (P1 at 128/380/1, P2 at 448) driven
// through movement, attack, stun and asynchronous reset scenarios.
module tb_player_fsm;

  logic       clk = 1'b0;
  logic       rst_n, ft;
  logic [3:0] bl, br, ba, gh, gb;
  logic [9:0] opp [4];
  logic [9:0] px  [4];
  logic [3:0] ps  [4];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  player_fsm #(.IS_P2(0), .START_X(10'd128)) u_a (
    .vga_clk(clk), .rst_n(rst_n), .frame_tick(ft),
    .btn_left(bl[0]), .btn_right(br[0]), .btn_attack(ba[0]),
    .got_hit(gh[0]), .got_blocked(gb[0]), .opponent_x(opp[0]),
    .player_x(px[0]), .player_state(ps[0]));

  player_fsm #(.IS_P2(0), .START_X(10'd380)) u_b (
    .vga_clk(clk), .rst_n(rst_n), .frame_tick(ft),
    .btn_left(bl[1]), .btn_right(br[1]), .btn_attack(ba[1]),
    .got_hit(gh[1]), .got_blocked(gb[1]), .opponent_x(opp[1]),
    .player_x(px[1]), .player_state(ps[1]));

  player_fsm #(.IS_P2(1), .START_X(10'd448)) u_c (
    .vga_clk(clk), .rst_n(rst_n), .frame_tick(ft),
    .btn_left(bl[2]), .btn_right(br[2]), .btn_attack(ba[2]),
    .got_hit(gh[2]), .got_blocked(gb[2]), .opponent_x(opp[2]),
    .player_x(px[2]), .player_state(ps[2]));

  player_fsm #(.IS_P2(0), .START_X(10'd1)) u_d (
    .vga_clk(clk), .rst_n(rst_n), .frame_tick(ft),
    .btn_left(bl[3]), .btn_right(br[3]), .btn_attack(ba[3]),
    .got_hit(gh[3]), .got_blocked(gb[3]), .opponent_x(opp[3]),
    .player_x(px[3]), .player_state(ps[3]));

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame_tick pulse, then one quiet cycle; returns 1 time unit after an edge.
  task automatic tick();
    ft = 1'b1;
    @(posedge clk); #1;
    ft = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int ea, ec;
    rst_n = 1'b0; ft = 1'b0;
    bl = '0; br = '0; ba = '0; gh = '0; gb = '0;
    opp[0] = 10'd448; opp[1] = 10'd448; opp[2] = 10'd128; opp[3] = 10'd448;
    @(posedge clk); #1;
    chk("rst_a_x", 11'(px[0]), 11'd128);
    chk("rst_a_st", 11'(ps[0]), 11'd0);
    chk("rst_c_x", 11'(px[2]), 11'd448);
    chk("rst_d_x", 11'(px[3]), 11'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Walking: free forward, forward into the opponent limit, backward into 0
    br[0] = 1'b1; br[1] = 1'b1; bl[3] = 1'b1;
    tick();
    chk("a_fwd1_st", 11'(ps[0]), 11'd1);
    chk("a_fwd1_x", 11'(px[0]), 11'd131);
    chk("b_fwd1_x", 11'(px[1]), 11'd383);
    chk("d_back_x", 11'(px[3]), 11'd0);
    chk("d_back_st", 11'(ps[3]), 11'd2);
    tick();
    chk("a_fwd2_x", 11'(px[0]), 11'd134);
    chk("b_fwd2_x", 11'(px[1]), 11'd384);
    chk("b_fwd2_st", 11'(ps[1]), 11'd1);
    tick();
    chk("a_fwd3_x", 11'(px[0]), 11'd137);
    tick();
    chk("a_fwd4_x", 11'(px[0]), 11'd140);
    chk("a_fwd4_st", 11'(ps[0]), 11'd1);
    chk("b_limit_x", 11'(px[1]), 11'd384);
    chk("d_floor_x", 11'(px[3]), 11'd0);
    chk("c_idle_st", 11'(ps[2]), 11'd0);
    br[0] = 1'b0; br[1] = 1'b0; bl[3] = 1'b1; br[3] = 1'b1;
    tick();
    chk("a_rel_st", 11'(ps[0]), 11'd0);
    chk("d_both_st", 11'(ps[3]), 11'd0);
    chk("d_both_x", 11'(px[3]), 11'd0);
    bl[3] = 1'b0; br[3] = 1'b0;

    // Neutral attack on A (held button), directional attack on P2
    ba[0] = 1'b1; ba[2] = 1'b1; bl[2] = 1'b1;
    for (int t = 1; t <= 23; t++) begin
      tick();
      ea = (t <= 5) ? 3 : (t <= 7) ? 4 : 5;
      ec = (t <= 4) ? 6 : (t <= 7) ? 7 : (t <= 22) ? 8 : 0;
      chk($sformatf("a_natk_t%0d", t), 11'(ps[0]), 11'(ea));
      chk($sformatf("c_datk_t%0d", t), 11'(ps[2]), 11'(ec));
    end
    chk("a_natk_x", 11'(px[0]), 11'd140);
    chk("c_datk_x", 11'(px[2]), 11'd448);
    tick();
    chk("a_natk_end", 11'(ps[0]), 11'd0);
    chk("c_walk_st", 11'(ps[2]), 11'd1);
    chk("c_walk_x", 11'(px[2]), 11'd445);
    bl[2] = 1'b0; ba[2] = 1'b0;
    tick();
    chk("a_noretrig", 11'(ps[0]), 11'd0);
    chk("c_rel_st", 11'(ps[2]), 11'd0);

    // Hit and block together during an active frame on P2
    ba[2] = 1'b1; bl[2] = 1'b1;
    for (int t = 1; t <= 5; t++) tick();
    chk("c_active", 11'(ps[2]), 11'd7);
    bl[2] = 1'b0; ba[2] = 1'b0;
    gh[2] = 1'b1; gb[2] = 1'b1;
    @(posedge clk); #1;
    gh[2] = 1'b0; gb[2] = 1'b0;
    chk("c_hit_st", 11'(ps[2]), 11'd9);
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk($sformatf("c_hit_t%0d", t), 11'(ps[2]), (t < 15) ? 11'd9 : 11'd0);
    end

    // Stun pulses coinciding with a frame tick override its transition
    br[0] = 1'b1; gh[0] = 1'b1; gb[2] = 1'b1; ft = 1'b1;
    @(posedge clk); #1;
    gh[0] = 1'b0; gb[2] = 1'b0; ft = 1'b0;
    chk("a_hit_st", 11'(ps[0]), 11'd9);
    chk("a_hit_x", 11'(px[0]), 11'd140);
    chk("c_blk_st", 11'(ps[2]), 11'd10);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("c_blk_t%0d", t), 11'(ps[2]), (t < 3) ? 11'd10 : 11'd0);
    end
    br[0] = 1'b0;
    for (int t = 4; t <= 15; t++) begin
      tick();
      if (t >= 14) chk($sformatf("a_hit_t%0d", t), 11'(ps[0]), (t < 15) ? 11'd9 : 11'd0);
    end
    chk("a_stun_x", 11'(px[0]), 11'd140);

    // Asynchronous reset in the middle of a recovery
    ba[0] = 1'b0;
    tick();
    ba[0] = 1'b1;
    for (int t = 1; t <= 8; t++) tick();
    chk("a_rec_st", 11'(ps[0]), 11'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_x", 11'(px[0]), 11'd128);
    chk("arst_a_st", 11'(ps[0]), 11'd0);
    chk("arst_c_x", 11'(px[2]), 11'd448);
    @(posedge clk); #1;
    rst_n = 1'b1;
    br[0] = 1'b1;
    tick();
    chk("post_rst_st", 11'(ps[0]), 11'd6);
    chk("post_rst_x", 11'(px[0]), 11'd128);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/player_fsm.md
PLAYER_FSM -- requirements
Module: player_fsm

Interface
REQ-001 Parameter IS_P2, default 0, meaning: 0 = player 1 faces +x (right), 1 = player 2 faces -x (left).
REQ-002 Parameter START_X, default 10'd128, meaning: player_x value loaded at reset.
REQ-003 Parameters SPD_FWD / SPD_BACK, defaults 3 / 2, meaning: pixels moved per frame forward / backward.
REQ-004 Parameters T_NSU/T_NACT/T_NREC, defaults 5/2/16, meaning: frame counts for neutral startup/active/recovery.
REQ-005 Parameters T_DSU/T_DACT/T_DREC, defaults 4/3/15, meaning: frame counts for directional startup/active/recovery.
REQ-006 Parameters T_HIT / T_BLK, defaults 15 / 3, meaning: hitstun / blockstun frame counts.
REQ-007 vga_clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-010 btn_left, btn_right, btn_attack  in  1 each  synchronized, debounced, active-high levels.
REQ-011 got_hit, got_blocked  in  1 each  one-cycle pulses from collision logic.
REQ-012 opponent_x  in  10  left edge of the opponent body.
REQ-013 player_x  out  10  left edge of this player's 64-px body, registered.
REQ-014 player_state  out  4  registered state code, per REQ-015.

Function
REQ-015 State codes SHALL be: 0 IDLE, 1 MOVE_FWD, 2 MOVE_BACK, 3 N_STARTUP, 4 N_ACTIVE, 5 N_RECOVERY, 6 D_STARTUP, 7 D_ACTIVE, 8 D_RECOVERY, 9 HITSTUN, 10 BLOCKSTUN; codes 11-15 SHALL never be output.
REQ-016 Forward SHALL be btn_right for IS_P2=0 and btn_left for IS_P2=1; the other button SHALL be backward.
REQ-017 Inputs SHALL be evaluated only on cycles with frame_tick=1, except got_hit/got_blocked (REQ-023).
REQ-018 Attack edge SHALL be btn_attack=1 at this frame_tick and 0 at the previous frame_tick (internal register, cleared by reset).
REQ-019 In IDLE/MOVE_FWD/MOVE_BACK at frame_tick, in priority order: attack edge with exactly one direction held -> D_STARTUP; attack edge otherwise -> N_STARTUP; exactly one direction held -> MOVE_FWD/MOVE_BACK with position updated on the same edge; else (none or both held) -> IDLE.
REQ-020 Timed states (3-10) SHALL load a frame counter with their duration on entry; at each frame_tick the counter decrements, and the tick on which it equals 1 causes the transition, so each phase lasts exactly its parameter value in frame_ticks.
REQ-021 Sequences: 3->4->5->0, 6->7->8->0, 9->0, 10->0; a 0 duration parameter SHALL behave as 1.
REQ-022 Buttons SHALL be ignored in states 3-10; player_x SHALL not change in states other than 1/2.
REQ-023 got_hit in any state SHALL force HITSTUN (counter=T_HIT) on the next edge; got_blocked likewise forces BLOCKSTUN (T_BLK); both asserted -> HITSTUN; a pulse coinciding with frame_tick overrides the frame_tick transition; re-hit during stun reloads the counter.
REQ-024 Movement arithmetic in 11 bits: P1 forward x' = min(x+SPD_FWD, opponent_x-64); P2 forward x' = max(x-SPD_FWD, opponent_x+64); backward moves away by SPD_BACK; result SHALL be clamped to [0, 576].
REQ-025 If the forward limit lies behind the current x (overlap or opponent_x<64 for P1), x SHALL stay unchanged; x SHALL never wrap below 0 or exceed 576.

Reset
REQ-026 rst_n=0 SHALL immediately set player_x=START_X, player_state=0, counter=0, attack-edge register=0, regardless of clock or mid-attack/stun state.
REQ-027 After rst_n rises, the first frame_tick SHALL be evaluated as from IDLE.

Verification
REQ-028 P1, x=128, opp=448, btn_right held 4 ticks -> state 1, x=131,134,137,140.
REQ-029 P1, x=380, opp=448, btn_right held 2 ticks -> x=383, 384; state stays 1.
REQ-030 P1 idle, btn_attack rises alone -> state 3 for 5 ticks, 4 for 2, 5 for 16, then 0; x constant; holding btn_attack throws no second attack.
REQ-031 P2 x=448, btn_attack rise with btn_left held -> state 6 (4 ticks), 7 (3), 8 (15), 0.
REQ-032 During state 7, got_hit and got_blocked same cycle -> state 9 next edge, 15 ticks, then 0; got_blocked alone -> 10 for 3 ticks.
REQ-033 P1 x=1, btn_left held -> x=0 and stays 0; rst_n pulsed low during state 5 -> x=128, state 0 without clock.
